// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory handshake,
// decode-side instruction handshake and status outputs.
interface ifetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_4;
    logic        instr_ready;
    logic [31:0] fetch_pc;
    logic        misalign_err;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_4,
               fetch_pc, misalign_err
    );

    // Environment side (memory, next-PC logic, decode).
    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_4,
               fetch_pc, misalign_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, a single
// holding slot toward decode, and redirect handling that never cancels a
// request already presented to memory (stale data is dropped instead).
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        misalign_q;
    logic [31:0] redirect_al;

    // Word-align every redirect target before it is used anywhere.
    assign redirect_al = {bus.redirect_pc[31:2], 2'b00};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (bus.imem_ack && !bus.redirect_valid) state_nxt = HOLD;
                else if (!bus.imem_ack && bus.redirect_valid) state_nxt = DROP;
            end
            DROP: if (bus.imem_ack) state_nxt = REQ;
            HOLD: if (bus.redirect_valid || bus.instr_ready) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: request while a read is outstanding, valid while holding.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        unique case (state)
            REQ, DROP: bus.imem_req    = 1'b1;
            HOLD:      bus.instr_valid = 1'b1;
            default: ;
        endcase
    end

    // PC, pending target, held instruction and sticky misalignment flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            pending_pc <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
                misalign_q <= 1'b1;
            unique case (state)
                IDLE: if (bus.redirect_valid) pc <= redirect_al;
                REQ: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect_valid) begin
                            pc <= redirect_al;
                        end else begin
                            instr_q    <= bus.imem_rdata;
                            instr_pc_q <= pc;
                        end
                    end else if (bus.redirect_valid) begin
                        pending_pc <= redirect_al;
                    end
                end
                DROP: begin
                    // The in-flight read completes with stale data; resume at
                    // the newest target, a same-cycle redirect winning.
                    if (bus.imem_ack)
                        pc <= bus.redirect_valid ? redirect_al : pending_pc;
                    else if (bus.redirect_valid)
                        pending_pc <= redirect_al;
                end
                HOLD: begin
                    if (bus.redirect_valid)   pc <= redirect_al;
                    else if (bus.instr_ready) pc <= pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.fetch_pc     = pc;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.instr_pc_4   = instr_pc_q + 32'd4;
    assign bus.misalign_err = misalign_q;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_3000, PC value loaded on reset and the first fetch address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 redirect_valid  input  1  a taken branch/jump/jr target is presented this cycle.
REQ-005 redirect_pc  input  32  target address from next-PC logic.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  32  word address of the request.
REQ-008 imem_ack  input  1  single-cycle pulse; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  instruction word returned.
REQ-010 instr_valid  output  1  instr/instr_pc/instr_pc_4 hold a fetched instruction.
REQ-011 instr  output  32  fetched instruction word.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 instr_pc_4  output  32  instr_pc + 4 (mod 2^32), for link and sequential next-PC.
REQ-014 instr_ready  input  1  decode accepts instr this cycle when instr_valid=1.
REQ-015 fetch_pc  output  32  current PC register.
REQ-016 misalign_err  output  1  sticky flag: a redirect with redirect_pc[1:0]!=0 was accepted.

Function
REQ-017 The block SHALL implement FSM states IDLE, REQ, DROP, HOLD.
REQ-018 IDLE: imem_req=0, instr_valid=0; next state REQ; if redirect_valid, pc<=redirect_pc first.
REQ-019 REQ: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack (no request cancel).
REQ-020 REQ with imem_ack and no redirect_valid: capture instr<=imem_rdata, instr_pc<=pc; go HOLD.
REQ-021 REQ with imem_ack and redirect_valid: discard imem_rdata, pc<=redirect_pc; stay REQ (new request with new address next cycle).
REQ-022 REQ with redirect_valid and no imem_ack: save target in pending register; go DROP.
REQ-023 DROP: imem_req=1 with the old address; a new redirect_valid overwrites the pending target (latest wins); on imem_ack discard data, pc<=pending target (or redirect_pc if redirect_valid in that same cycle); go REQ.
REQ-024 HOLD: instr_valid=1, outputs stable until accepted or flushed; imem_req=0.
REQ-025 HOLD with redirect_valid: drop held instruction (instr_valid=0 next cycle), pc<=redirect_pc, go REQ; redirect has priority over instr_ready.
REQ-026 HOLD with instr_ready and no redirect: pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), go REQ.
REQ-027 Latency: redirect accepted in cycle N -> imem_req with imem_addr=redirect_pc in cycle N+1; imem_ack in cycle M -> instr_valid=1 in cycle M+1.
REQ-028 Accepted redirect_pc SHALL have bits [1:0] forced to 0 before use; if they were nonzero, misalign_err is set and held until reset.
REQ-029 fetch_pc SHALL always equal the pc register; instr_pc_4 SHALL be computed combinationally from instr_pc.
REQ-030 imem_ack outside REQ/DROP SHALL be ignored.

Reset
REQ-031 While reset=0: state=IDLE, pc=RESET_PC, pending=0, instr=0, instr_pc=0, instr_valid=0, imem_req=0, misalign_err=0, asynchronously.
REQ-032 Reset asserted mid-request abandons the transaction; no held or in-flight instruction survives; first request after release is to RESET_PC.

Verification
REQ-033 Release reset, ack every request after 1 cycle with rdata=addr, instr_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_pc_4 = instr_pc+4.
REQ-034 Hold instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc constant, imem_req=0; ready=1 -> next imem_addr=instr_pc+4.
REQ-035 Redirect to 0x3100 in REQ without ack, ack 3 cycles later -> that rdata never appears on instr; next imem_addr=0x3100.
REQ-036 Redirect to 0x3200 in HOLD with instr_ready=1 -> held instruction dropped, next imem_addr=0x3200.
REQ-037 Redirect to 0x3103 -> imem_addr=0x3100, misalign_err=1 until reset.
REQ-038 Assert reset during DROP -> all outputs at reset values immediately; after release imem_addr=0x3000.
